// File: rtl/pi_region_decoder.sv
// -----------------------------------------------------------------------------
// pi_region_decoder
//
// Runtime-programmable PI address decoder. NUM_REGIONS windows, each described
// by a BASE, a MASK and an enable bit, are written by the CPU over a simple
// config bus. Incoming request addresses are matched against every enabled
// window. The lowest-numbered matching window wins. The decode result is
// registered in a single valid/ready pipeline stage.
//
// A window r matches when EN[r] && ((addr & MASK[r]) == (BASE[r] & MASK[r])).
// Set MASK bits are the compared bits. A window with MASK=0 matches any address.
//
// Optional feature (compile-time macro PI_REGION_DECODER_MISS_LOG_EN):
//   adds a saturating miss counter, a last-miss address register and a
//   clear input. When the macro is undefined these ports and registers are
//   absent and decode behaviour is unchanged.
//
// Ports
//   i_clk            system clock
//   i_reset_n        asynchronous reset, active-low
//   i_cfg_write      config write strobe
//   i_cfg_region     region being written
//   i_cfg_field      0=BASE, 1=MASK, 2=CTRL (bit0=enable), 3=ignored
//   i_cfg_data       config write data
//   i_req_valid      request address valid
//   o_req_ready      decoder can accept a request
//   i_req_address    request address
//   o_rsp_valid      decode result valid
//   i_rsp_ready      consumer accepts the result
//   o_rsp_hit        some enabled region matched
//   o_rsp_select     one-hot region select (zero on miss)
//   o_rsp_index      matched region index (zero on miss)
//   o_rsp_offset     address & ~MASK[index] (full address on miss)
//   i_miss_clear     (miss log only) zero the miss counter and address
//   o_miss_count     (miss log only) saturating count of accepted misses
//   o_miss_address   (miss log only) last accepted address that missed
// -----------------------------------------------------------------------------
module pi_region_decoder #(
    parameter int NUM_REGIONS = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int IDX_WIDTH   = 3
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,

    input  logic                   i_cfg_write,
    input  logic [IDX_WIDTH-1:0]   i_cfg_region,
    input  logic [1:0]             i_cfg_field,
    input  logic [ADDR_WIDTH-1:0]  i_cfg_data,

    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [ADDR_WIDTH-1:0]  i_req_address,

    output logic                   o_rsp_valid,
    input  logic                   i_rsp_ready,
    output logic                   o_rsp_hit,
    output logic [NUM_REGIONS-1:0] o_rsp_select,
    output logic [IDX_WIDTH-1:0]   o_rsp_index,
    output logic [ADDR_WIDTH-1:0]  o_rsp_offset
`ifdef PI_REGION_DECODER_MISS_LOG_EN
    ,
    input  logic                   i_miss_clear,
    output logic [15:0]            o_miss_count,
    output logic [ADDR_WIDTH-1:0]  o_miss_address
`endif
);

    // Config field encodings.
    localparam logic [1:0] FIELD_BASE = 2'd0;
    localparam logic [1:0] FIELD_MASK = 2'd1;
    localparam logic [1:0] FIELD_CTRL = 2'd2;

    // -------------------------------------------------------------------------
    // Window registers
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]  base_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  base_d [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  mask_q [NUM_REGIONS];
    logic [ADDR_WIDTH-1:0]  mask_d [NUM_REGIONS];
    logic [NUM_REGIONS-1:0] en_q;
    logic [NUM_REGIONS-1:0] en_d;

    // Region selection compares against every legal index, so a region number
    // at or above NUM_REGIONS simply selects nothing and the write is dropped.
    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional assignment; a missed branch would otherwise infer a latch.
        base_d = base_q;
        mask_d = mask_q;
        en_d   = en_q;
        for (int r = 0; r < NUM_REGIONS; r++) begin
            if (i_cfg_write && (i_cfg_region == IDX_WIDTH'(r))) begin
                case (i_cfg_field)
                    FIELD_BASE: base_d[r] = i_cfg_data;
                    FIELD_MASK: mask_d[r] = i_cfg_data;
                    FIELD_CTRL: en_d[r]   = i_cfg_data[0];
                    default:    ;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            // NOTE: the window table is small and must come up as all-disabled
            // with zero base/mask, so it is reset like any other register
            // rather than left as uninitialised storage.
            for (int r = 0; r < NUM_REGIONS; r++) begin
                base_q[r] <= '0;
                mask_q[r] <= '0;
            end
            en_q <= '0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments
            // so every register samples values from before this edge.
            base_q <= base_d;
            mask_q <= mask_d;
            en_q   <= en_d;
        end
    end

    // -------------------------------------------------------------------------
    // Combinational decode of the incoming address against the current
    // (pre-edge) window registers. A config write landing on the same edge as
    // an accept therefore does not affect that request.
    // -------------------------------------------------------------------------
    logic [NUM_REGIONS-1:0] match;
    logic                   dec_hit;
    logic [NUM_REGIONS-1:0] dec_select;
    logic [IDX_WIDTH-1:0]   dec_index;
    logic [ADDR_WIDTH-1:0]  dec_offset;

    always_comb begin
        for (int r = 0; r < NUM_REGIONS; r++) begin
            match[r] = en_q[r] &&
                       ((i_req_address & mask_q[r]) == (base_q[r] & mask_q[r]));
        end
    end

    // Scanning from the highest index down lets the lowest matching index
    // overwrite the others, giving lowest-index priority without a break.
    always_comb begin
        dec_hit    = 1'b0;
        dec_select = '0;
        dec_index  = '0;
        dec_offset = i_req_address;
        for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
            if (match[r]) begin
                dec_hit       = 1'b1;
                dec_select    = '0;
                dec_select[r] = 1'b1;
                dec_index     = IDX_WIDTH'(r);
                dec_offset    = i_req_address & ~mask_q[r];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Response pipeline stage
    // -------------------------------------------------------------------------
    logic                   rsp_valid_q,  rsp_valid_d;
    logic                   rsp_hit_q,    rsp_hit_d;
    logic [NUM_REGIONS-1:0] rsp_select_q, rsp_select_d;
    logic [IDX_WIDTH-1:0]   rsp_index_q,  rsp_index_d;
    logic [ADDR_WIDTH-1:0]  rsp_offset_q, rsp_offset_d;
    logic                   req_accept;

    // The stage can take a new request whenever it is empty or its current
    // content leaves on this same edge, giving one result per cycle.
    assign o_req_ready = !rsp_valid_q || i_rsp_ready;
    assign req_accept  = i_req_valid && o_req_ready;

    // Result fields change only on accept, so a stalled result holds and a
    // result in flight is never re-evaluated after a config write.
    always_comb begin
        rsp_valid_d  = rsp_valid_q;
        rsp_hit_d    = rsp_hit_q;
        rsp_select_d = rsp_select_q;
        rsp_index_d  = rsp_index_q;
        rsp_offset_d = rsp_offset_q;
        if (req_accept) begin
            rsp_valid_d  = 1'b1;
            rsp_hit_d    = dec_hit;
            rsp_select_d = dec_select;
            rsp_index_d  = dec_index;
            rsp_offset_d = dec_offset;
        end else if (i_rsp_ready) begin
            rsp_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            rsp_valid_q  <= 1'b0;
            rsp_hit_q    <= 1'b0;
            rsp_select_q <= '0;
            rsp_index_q  <= '0;
            rsp_offset_q <= '0;
        end else begin
            rsp_valid_q  <= rsp_valid_d;
            rsp_hit_q    <= rsp_hit_d;
            rsp_select_q <= rsp_select_d;
            rsp_index_q  <= rsp_index_d;
            rsp_offset_q <= rsp_offset_d;
        end
    end

    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_hit    = rsp_hit_q;
    assign o_rsp_select = rsp_select_q;
    assign o_rsp_index  = rsp_index_q;
    assign o_rsp_offset = rsp_offset_q;

`ifdef PI_REGION_DECODER_MISS_LOG_EN
    // -------------------------------------------------------------------------
    // Miss log: counts accepted requests that matched no window. A clear in
    // the same cycle as a miss takes precedence and the miss is dropped.
    // -------------------------------------------------------------------------
    logic [15:0]           miss_count_q,   miss_count_d;
    logic [ADDR_WIDTH-1:0] miss_address_q, miss_address_d;

    always_comb begin
        miss_count_d   = miss_count_q;
        miss_address_d = miss_address_q;
        if (i_miss_clear) begin
            miss_count_d   = '0;
            miss_address_d = '0;
        end else if (req_accept && !dec_hit) begin
            if (miss_count_q != 16'hFFFF) begin
                miss_count_d = miss_count_q + 16'd1;
            end
            miss_address_d = i_req_address;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            miss_count_q   <= '0;
            miss_address_q <= '0;
        end else begin
            miss_count_q   <= miss_count_d;
            miss_address_q <= miss_address_d;
        end
    end

    assign o_miss_count   = miss_count_q;
    assign o_miss_address = miss_address_q;
`endif

endmodule

// File: tb/tb_pi_region_decoder.sv
// -----------------------------------------------------------------------------
// tb_pi_region_decoder
//
// Self-checking bench for pi_region_decoder with default parameters.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_pi_region_decoder;

    localparam int NR = 8;
    localparam int AW = 32;
    localparam int IW = 3;

    logic          clk;
    logic          reset_n;
    logic          cfg_write;
    logic [IW-1:0] cfg_region;
    logic [1:0]    cfg_field;
    logic [AW-1:0] cfg_data;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_address;
    logic          rsp_valid;
    logic          rsp_ready;
    logic          rsp_hit;
    logic [NR-1:0] rsp_select;
    logic [IW-1:0] rsp_index;
    logic [AW-1:0] rsp_offset;
`ifdef PI_REGION_DECODER_MISS_LOG_EN
    logic          miss_clear;
    logic [15:0]   miss_count;
    logic [AW-1:0] miss_address;
`endif

    pi_region_decoder #(
        .NUM_REGIONS (NR),
        .ADDR_WIDTH  (AW),
        .IDX_WIDTH   (IW)
    ) dut (
        .i_clk         (clk),
        .i_reset_n     (reset_n),
        .i_cfg_write   (cfg_write),
        .i_cfg_region  (cfg_region),
        .i_cfg_field   (cfg_field),
        .i_cfg_data    (cfg_data),
        .i_req_valid   (req_valid),
        .o_req_ready   (req_ready),
        .i_req_address (req_address),
        .o_rsp_valid   (rsp_valid),
        .i_rsp_ready   (rsp_ready),
        .o_rsp_hit     (rsp_hit),
        .o_rsp_select  (rsp_select),
        .o_rsp_index   (rsp_index),
        .o_rsp_offset  (rsp_offset)
`ifdef PI_REGION_DECODER_MISS_LOG_EN
        ,
        .i_miss_clear   (miss_clear),
        .o_miss_count   (miss_count),
        .o_miss_address (miss_address)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // ---------------------------- reference model ----------------------------
    typedef struct {
        logic          hit;
        logic [NR-1:0] sel;
        logic [IW-1:0] idx;
        logic [AW-1:0] off;
    } rsp_t;

    logic [AW-1:0] m_base [NR];
    logic [AW-1:0] m_mask [NR];
    logic          m_en   [NR];

    function automatic rsp_t model_decode(input logic [AW-1:0] a);
        rsp_t r;
        r.hit = 1'b0;
        r.sel = '0;
        r.idx = '0;
        r.off = a;
        for (int k = 0; k < NR; k++) begin
            if (m_en[k] && ((a & m_mask[k]) == (m_base[k] & m_mask[k]))) begin
                r.hit = 1'b1;
                r.sel = NR'(1) << k;
                r.idx = IW'(k);
                r.off = a & ~m_mask[k];
                break;
            end
        end
        return r;
    endfunction

    function automatic void model_cfg(input int region, input int field, input logic [AW-1:0] d);
        if (region < NR) begin
            if (field == 0) m_base[region] = d;
            else if (field == 1) m_mask[region] = d;
            else if (field == 2) m_en[region] = d[0];
        end
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < NR; k++) begin
            m_base[k] = '0;
            m_mask[k] = '0;
            m_en[k]   = 1'b0;
        end
    endfunction

    function automatic logic [AW-1:0] gen_addr();
        int k;
        k = $urandom_range(0, NR - 1);
        if ($urandom_range(0, 1) == 1)
            return (m_base[k] & m_mask[k]) | ($urandom() & ~m_mask[k]);
        return $urandom();
    endfunction

    // ------------------------------- helpers ---------------------------------
    // All helpers start and end on a falling edge.
    task automatic cfg(input int region, input int field, input logic [AW-1:0] d);
        cfg_write  = 1'b1;
        cfg_region = IW'(region);
        cfg_field  = 2'(field);
        cfg_data   = d;
        @(negedge clk);
        cfg_write  = 1'b0;
        model_cfg(region, field, d);
    endtask

    task automatic single_req(input logic [AW-1:0] a);
        req_valid   = 1'b1;
        req_address = a;
        rsp_ready   = 1'b1;
        @(negedge clk);
        req_valid   = 1'b0;
    endtask

    task automatic check_rsp(input string n, input logic h, input logic [NR-1:0] s,
                             input logic [IW-1:0] i, input logic [AW-1:0] o);
        check({n, "_valid"},  32'(rsp_valid),  32'd1);
        check({n, "_hit"},    32'(rsp_hit),    32'(h));
        check({n, "_select"}, 32'(rsp_select), 32'(s));
        check({n, "_index"},  32'(rsp_index),  32'(i));
        check({n, "_offset"}, rsp_offset,      o);
    endtask

    // ----------------------------- vector table ------------------------------
    typedef struct {
        logic          r0_wr;
        logic [AW-1:0] r0_ctrl;
        logic [AW-1:0] addr;
        logic          hit;
        logic [NR-1:0] sel;
        logic [IW-1:0] idx;
        logic [AW-1:0] off;
    } vec_t;

    localparam int NVEC = 9;
    vec_t vecs [NVEC];

    rsp_t exp_r;
    logic exp_valid;

    initial begin
        // R1 = 1800_0000/FF00_0000, R2 = 1000_0000/F000_0000, R0 = catch-all when enabled
        vecs[0] = '{1'b0, 32'h0, 32'h1800_0010, 1'b1, 8'h02, 3'd1, 32'h0000_0010};
        vecs[1] = '{1'b0, 32'h0, 32'h1000_0000, 1'b1, 8'h04, 3'd2, 32'h0000_0000};
        vecs[2] = '{1'b0, 32'h0, 32'h1FFF_FFFF, 1'b1, 8'h04, 3'd2, 32'h0FFF_FFFF};
        vecs[3] = '{1'b0, 32'h0, 32'h18FF_FFFF, 1'b1, 8'h02, 3'd1, 32'h00FF_FFFF};
        vecs[4] = '{1'b0, 32'h0, 32'h2000_0000, 1'b0, 8'h00, 3'd0, 32'h2000_0000};
        vecs[5] = '{1'b0, 32'h0, 32'h0FFF_FFFF, 1'b0, 8'h00, 3'd0, 32'h0FFF_FFFF};
        vecs[6] = '{1'b1, 32'h3, 32'h2000_0000, 1'b1, 8'h01, 3'd0, 32'h2000_0000};
        vecs[7] = '{1'b0, 32'h0, 32'h1800_0010, 1'b1, 8'h01, 3'd0, 32'h1800_0010};
        vecs[8] = '{1'b1, 32'h0, 32'h1800_0010, 1'b1, 8'h02, 3'd1, 32'h0000_0010};

        model_reset();
        reset_n     = 1'b0;
        cfg_write   = 1'b0;
        cfg_region  = '0;
        cfg_field   = '0;
        cfg_data    = '0;
        req_valid   = 1'b0;
        req_address = '0;
        rsp_ready   = 1'b0;
`ifdef PI_REGION_DECODER_MISS_LOG_EN
        miss_clear  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset state
        check("rst_valid",  32'(rsp_valid),  32'd0);
        check("rst_hit",    32'(rsp_hit),    32'd0);
        check("rst_select", 32'(rsp_select), 32'd0);
        check("rst_index",  32'(rsp_index),  32'd0);
        check("rst_offset", rsp_offset,      32'd0);
        check("rst_ready",  32'(req_ready),  32'd1);

        // Unconfigured decoder misses
        single_req(32'h1000_0000);
        check_rsp("noconf", 1'b0, 8'h00, 3'd0, 32'h1000_0000);

        // Single window
        cfg(2, 0, 32'h1000_0000);
        cfg(2, 1, 32'hFC00_0000);
        cfg(2, 2, 32'h1);
        single_req(32'h13FF_FFFC);
        check_rsp("r2", 1'b1, 8'h04, 3'd2, 32'h03FF_FFFC);

        // Overlapping windows; field 3 and CTRL bit 1 must not enable R0
        cfg(1, 0, 32'h1800_0000);
        cfg(1, 1, 32'hFF00_0000);
        cfg(1, 2, 32'h1);
        cfg(2, 1, 32'hF000_0000);
        cfg(0, 3, 32'hFFFF_FFFF);
        cfg(0, 2, 32'h2);
        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].r0_wr) cfg(0, 2, vecs[i].r0_ctrl);
            single_req(vecs[i].addr);
            check_rsp($sformatf("vec%0d", i), vecs[i].hit, vecs[i].sel, vecs[i].idx, vecs[i].off);
        end

        // Backpressure: result holds, second request waits, then no bubble
        rsp_ready   = 1'b0;
        req_valid   = 1'b1;
        req_address = 32'h1800_0010;
        @(negedge clk);
        req_address = 32'h1000_0000;
        #1;
        check("bp_ready_low", 32'(req_ready), 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_rsp($sformatf("bp_hold%0d", c), 1'b1, 8'h02, 3'd1, 32'h0000_0010);
            check($sformatf("bp_hold%0d_ready", c), 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        #1;
        check("bp_ready_release", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check_rsp("bp_second", 1'b1, 8'h04, 3'd2, 32'h0000_0000);
        @(negedge clk);
        check("bp_drained", 32'(rsp_valid), 32'd0);

        // Config write on the accept edge: the request sees the old enable
        cfg_write   = 1'b1;
        cfg_region  = 3'd2;
        cfg_field   = 2'd2;
        cfg_data    = 32'h0;
        req_valid   = 1'b1;
        req_address = 32'h1000_0000;
        @(negedge clk);
        cfg_write   = 1'b0;
        req_valid   = 1'b0;
        model_cfg(2, 2, 32'h0);
        check_rsp("samecyc_old", 1'b1, 8'h04, 3'd2, 32'h0000_0000);
        single_req(32'h1000_0000);
        check_rsp("samecyc_new", 1'b0, 8'h00, 3'd0, 32'h1000_0000);

        // A stalled result is not re-evaluated by a later config write
        cfg(2, 2, 32'h1);
        rsp_ready   = 1'b0;
        req_valid   = 1'b1;
        req_address = 32'h1000_0000;
        @(negedge clk);
        req_valid = 1'b0;
        cfg(2, 2, 32'h0);
        check_rsp("inflight", 1'b1, 8'h04, 3'd2, 32'h0000_0000);
        rsp_ready = 1'b1;
        @(negedge clk);
        check("inflight_drained", 32'(rsp_valid), 32'd0);

        // Randomised traffic with config writes against the model
        exp_valid = 1'b0;
        exp_r     = model_decode(32'h0);
        for (int c = 0; c < 2000; c++) begin
            if (exp_valid) begin
                check_rsp($sformatf("rnd%0d", c), exp_r.hit, exp_r.sel, exp_r.idx, exp_r.off);
            end else begin
                check($sformatf("rnd%0d_valid", c), 32'(rsp_valid), 32'd0);
            end
            req_valid   = ($urandom_range(0, 3) != 0);
            rsp_ready   = ($urandom_range(0, 3) != 0);
            req_address = gen_addr();
            cfg_write   = ($urandom_range(0, 7) == 0);
            cfg_region  = IW'($urandom_range(0, NR - 1));
            cfg_field   = 2'($urandom_range(0, 3));
            if (cfg_field == 2'd1 && $urandom_range(0, 1) == 1)
                cfg_data = 32'hFFFF_FFFF << $urandom_range(0, 31);
            else
                cfg_data = $urandom();
            #1;
            check($sformatf("rnd%0d_ready", c), 32'(req_ready), 32'(!exp_valid || rsp_ready));
            if (req_valid && (!exp_valid || rsp_ready)) begin
                exp_r     = model_decode(req_address);
                exp_valid = 1'b1;
            end else if (rsp_ready) begin
                exp_valid = 1'b0;
            end
            if (cfg_write) model_cfg(int'(cfg_region), int'(cfg_field), cfg_data);
            @(negedge clk);
        end
        cfg_write = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);

        // Reset while a result is stalled
        rsp_ready   = 1'b0;
        req_valid   = 1'b1;
        req_address = 32'h0000_1234;
        @(negedge clk);
        req_valid = 1'b0;
        check("midrst_pre_valid", 32'(rsp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_valid",  32'(rsp_valid), 32'd0);
        check("midrst_hit",    32'(rsp_hit),   32'd0);
        check("midrst_offset", rsp_offset,     32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        @(negedge clk);
        single_req(32'h1800_0010);
        check_rsp("postrst", 1'b0, 8'h00, 3'd0, 32'h1800_0010);

`ifdef PI_REGION_DECODER_MISS_LOG_EN
        check("ml_after_rst_count", 32'(miss_count), 32'd1);
        check("ml_after_rst_addr",  miss_address,    32'h1800_0010);
        miss_clear = 1'b1;
        @(negedge clk);
        miss_clear = 1'b0;
        check("ml_clear_count", 32'(miss_count), 32'd0);
        single_req(32'h0000_0100);
        single_req(32'h0000_0200);
        single_req(32'h0000_0300);
        cfg(0, 2, 32'h1);
        single_req(32'h0000_0400);
        check_rsp("ml_hit", 1'b1, 8'h01, 3'd0, 32'h0000_0400);
        check("ml_count3", 32'(miss_count), 32'd3);
        check("ml_addr3",  miss_address,    32'h0000_0300);
        cfg(0, 2, 32'h0);
        miss_clear  = 1'b1;
        req_valid   = 1'b1;
        req_address = 32'h0000_0500;
        @(negedge clk);
        miss_clear = 1'b0;
        req_valid  = 1'b0;
        check_rsp("ml_clrmiss", 1'b0, 8'h00, 3'd0, 32'h0000_0500);
        check("ml_clrmiss_count", 32'(miss_count), 32'd0);
        check("ml_clrmiss_addr",  miss_address,    32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
